// File: rtl/vs_pattern_gen.sv
// vs_pattern_gen: video stream source producing frames with a bouncing solid
// box, driving the per_frame_vsync / href / clken / 24-bit pixel interface.
// Optional feature macro: VS_PATGEN_BAR_EN (8 vertical colour bars as the
// background instead of BG_COLOR).
module vs_pattern_gen #(
   parameter int          IMG_WIDTH  = 800,
   parameter int          IMG_HEIGHT = 600,
   parameter int          H_BLANK    = 40,
   parameter int          V_BLANK    = 10,
   parameter int          VS_LINES   = 2,
   parameter int          BOX_SIZE   = 64,
   parameter int          STEP       = 4,
   parameter logic [23:0] BOX_COLOR  = 24'hFFFFFF,
   parameter logic [23:0] BG_COLOR   = 24'h000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        gen_en,
   output logic        per_frame_vsync,
   output logic        per_frame_href,
   output logic        per_frame_clken,
   output logic [23:0] per_img_24bit,
   output logic [15:0] frame_cnt,
   output logic        busy
);

   localparam logic [15:0] H_LAST = 16'(IMG_WIDTH + H_BLANK - 1);
   localparam logic [15:0] V_LAST = 16'(IMG_HEIGHT + V_BLANK - 1);
   localparam logic [15:0] W16    = 16'(IMG_WIDTH);
   localparam logic [15:0] H16    = 16'(IMG_HEIGHT);
   localparam logic [15:0] VB16   = 16'(V_BLANK);
   localparam logic [15:0] VS16   = 16'(VS_LINES);
   localparam logic [15:0] BOX16  = 16'(BOX_SIZE);
   localparam logic [15:0] STEP16 = 16'(STEP);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t      state_q, state_d;
   logic        cnt_act;
   logic [15:0] h_cnt, v_cnt;
   logic        h_wrap, frame_end;
   logic [15:0] bx, by;
   logic        dir_x, dir_y;
   logic        vsync_p0, href_p0;
   logic [23:0] pix_p0;
   logic [23:0] bg_p0;
   logic [15:0] py;
   logic        in_box;

   // One axis of box motion: advance by STEP, bouncing off either edge.
   // Returns {new_dir, new_pos}; dir 0 = increasing, 1 = decreasing.
   function automatic logic [16:0] step_axis(input logic [15:0] pos,
                                             input logic        dir,
                                             input logic [15:0] limit);
      logic [16:0] res;
      if (!dir && (pos + BOX16 + STEP16 > limit))
         res = {1'b1, limit - BOX16};
      else if (dir && (pos < STEP16))
         res = {1'b0, 16'd0};
      else if (!dir)
         res = {1'b0, pos + STEP16};
      else
         res = {1'b1, pos - STEP16};
      return res;
   endfunction

`ifdef VS_PATGEN_BAR_EN
   localparam logic [15:0] BAR_W = 16'(IMG_WIDTH / 8);

   logic [15:0] bar_sub;
   logic [2:0]  bar_idx;

   function automatic logic [23:0] bar_color(input logic [2:0] idx);
      logic [23:0] c;
      case (idx)
         3'd0:    c = 24'hFFFFFF;
         3'd1:    c = 24'hFFFF00;
         3'd2:    c = 24'h00FFFF;
         3'd3:    c = 24'h00FF00;
         3'd4:    c = 24'hFF00FF;
         3'd5:    c = 24'hFF0000;
         3'd6:    c = 24'h0000FF;
         default: c = 24'h000000;
      endcase
      return c;
   endfunction

   // Bar index tracks h_cnt / (IMG_WIDTH/8) with a sub-counter instead of a divider.
   always_ff @(posedge clk) begin
      if (rst || !cnt_act || h_wrap) begin
         bar_sub <= '0;
         bar_idx <= '0;
      end else if (bar_sub == BAR_W - 16'd1) begin
         bar_sub <= '0;
         bar_idx <= bar_idx + 3'd1;
      end else begin
         bar_sub <= bar_sub + 16'd1;
      end
   end

   assign bg_p0 = bar_color(bar_idx);
`else
   assign bg_p0 = BG_COLOR;
`endif

   assign h_wrap    = cnt_act && (h_cnt == H_LAST);
   assign frame_end = h_wrap && (v_cnt == V_LAST);
   assign busy      = (state_q != S_IDLE);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic: a frame, once started, always runs to its last cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (gen_en) state_d = S_RUN;
         S_RUN: begin
            if (frame_end) begin
               if (!gen_en) state_d = S_IDLE;
            end else if (!gen_en) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: if (frame_end) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Raster counters; cnt_act delays counting one cycle after leaving IDLE,
   // so the first frame cycle (0,0) starts on the edge after gen_en is taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_act <= 1'b0;
         h_cnt   <= '0;
         v_cnt   <= '0;
      end else begin
         cnt_act <= (state_q != S_IDLE) && (state_d != S_IDLE);
         if (cnt_act) begin
            if (h_wrap) begin
               h_cnt <= '0;
               v_cnt <= (v_cnt == V_LAST) ? 16'd0 : v_cnt + 16'd1;
            end else begin
               h_cnt <= h_cnt + 16'd1;
            end
         end else begin
            h_cnt <= '0;
            v_cnt <= '0;
         end
      end
   end

   // Box position and frame counter advance together on the last frame cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         bx        <= '0;
         by        <= '0;
         dir_x     <= 1'b0;
         dir_y     <= 1'b0;
         frame_cnt <= '0;
      end else if (frame_end) begin
         {dir_x, bx} <= step_axis(bx, dir_x, W16);
         {dir_y, by} <= step_axis(by, dir_y, H16);
         frame_cnt   <= frame_cnt + 16'd1;
      end
   end

   // Stage p0: counter decode.
   assign py       = v_cnt - VB16;
   assign vsync_p0 = cnt_act && (v_cnt < VS16);
   assign href_p0  = cnt_act && (v_cnt >= VB16) && (h_cnt < W16);
   assign in_box   = (h_cnt >= bx) && (h_cnt < bx + BOX16) &&
                     (py >= by) && (py < by + BOX16);
   assign pix_p0   = !href_p0 ? 24'h000000 : (in_box ? BOX_COLOR : bg_p0);

   // Stage p1: registered stream outputs, cleared immediately by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         per_frame_vsync <= 1'b0;
         per_frame_href  <= 1'b0;
         per_frame_clken <= 1'b0;
         per_img_24bit   <= '0;
      end else begin
         per_frame_vsync <= vsync_p0;
         per_frame_href  <= href_p0;
         per_frame_clken <= href_p0;
         per_img_24bit   <= pix_p0;
      end
   end

endmodule

// File: tb/tb_vs_pattern_gen.sv
// Directed bench for vs_pattern_gen using a 16x8 image, 220-clk frame.
// Sample k is taken 1 time unit after the k-th edge following release;
// the stream output in sample k reflects frame time t = k-2.
module tb_vs_pattern_gen;

   localparam int W = 16, HT = 8, HB = 4, VB = 3, VS = 1, BOX = 4, STP = 3;
   localparam int LINE = W + HB;       // 20
   localparam int FRAME = LINE * (HT + VB); // 220
   localparam int CAP = 1780;

   logic        clk, rst, gen_en;
   logic        vsync, href, clken, busy;
   logic [23:0] pix;
   logic [15:0] fcnt;

   logic        vs_a [CAP];
   logic        hr_a [CAP];
   logic        ce_a [CAP];
   logic        bz_a [CAP];
   logic [23:0] px_a [CAP];
   logic [15:0] fc_a [CAP];

   int n_err, n_chk;

   vs_pattern_gen #(
      .IMG_WIDTH(W), .IMG_HEIGHT(HT), .H_BLANK(HB), .V_BLANK(VB),
      .VS_LINES(VS), .BOX_SIZE(BOX), .STEP(STP),
      .BOX_COLOR(24'hFFFFFF), .BG_COLOR(24'h000000)
   ) dut (
      .clk(clk), .rst(rst), .gen_en(gen_en),
      .per_frame_vsync(vsync), .per_frame_href(href), .per_frame_clken(clken),
      .per_img_24bit(pix), .frame_cnt(fcnt), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] bg_of(input int h);
`ifdef VS_PATGEN_BAR_EN
      logic [23:0] bars [8];
      bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
      return bars[h / 2];
`else
      return (h < 0) ? 24'h1 : 24'h000000;
`endif
   endfunction

   task automatic capture(input int n, input int drop_k);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         vs_a[k] = vsync; hr_a[k] = href; ce_a[k] = clken;
         bz_a[k] = busy;  px_a[k] = pix;  fc_a[k] = fcnt;
         if (k == drop_k) gen_en = 1'b0;
      end
   endtask

   // Compare one full frame of stream outputs against the raster definition.
   task automatic check_frame(input string tag, input int f, input int ebx, input int eby);
      int mism, runs, high;
      mism = 0; runs = 0; high = 0;
      for (int t = 0; t < FRAME; t++) begin
         int k, h, v;
         logic evs, ehr;
         logic [23:0] epx;
         k = FRAME * f + t + 2; h = t % LINE; v = t / LINE;
         evs = (v < VS);
         ehr = (v >= VB) && (h < W);
         epx = !ehr ? 24'h0 :
               ((h >= ebx) && (h < ebx + BOX) && (v - VB >= eby) && (v - VB < eby + BOX))
               ? 24'hFFFFFF : bg_of(h);
         if (vs_a[k] !== evs || hr_a[k] !== ehr || ce_a[k] !== ehr || px_a[k] !== epx) mism++;
         if (hr_a[k] && !hr_a[k-1]) runs++;
         if (hr_a[k]) high++;
      end
      chk({tag, "_mism"}, mism, 0);
      chk({tag, "_runs"}, runs, 8);
      chk({tag, "_high"}, high, 8 * W);
   endtask

   task automatic find_box(input int f, output int fbx, output int fby);
      fbx = -1; fby = -1;
      for (int t = 0; t < FRAME; t++) begin
         int k;
         k = FRAME * f + t + 2;
         if (fbx < 0 && hr_a[k] && px_a[k] == 24'hFFFFFF
`ifdef VS_PATGEN_BAR_EN
             && ((t % LINE) >= 2 || (t / LINE - VB) < 4)
`endif
            ) begin
            fbx = t % LINE;
            fby = t / LINE - VB;
         end
      end
   endtask

   initial begin
      int exp_bx [8];
      int exp_by [8];
      int fbx, fby, cnt, first_hr, last_vs;
      bit found;
      exp_bx = '{0, 3, 6, 9, 12, 12, 9, 6};
      exp_by = '{0, 3, 4, 1, 0, 3, 4, 1};
      n_err = 0; n_chk = 0;
      rst = 1'b1; gen_en = 1'b1;

      // Reset held with gen_en high: everything stays quiet.
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("rst_out", {4'b0, vsync, href, clken, busy, pix}, 32'h0);
         chk("rst_fcnt", fcnt, 0);
      end
      rst = 1'b0;
      capture(CAP, -1);

      // Start latency and sync timing.
      chk("busy_k0", bz_a[0], 1);
      chk("vs_k1", vs_a[1], 0);
      chk("vs_k2", vs_a[2], 1);
      chk("vs_k21", vs_a[21], 1);
      chk("vs_k22", vs_a[22], 0);
      cnt = 0;
      for (int k = 0; k < FRAME; k++) if (vs_a[k]) cnt++;
      chk("vs_width", cnt, 20);
      first_hr = -1; last_vs = -1;
      for (int k = 0; k < FRAME; k++) begin
         if (first_hr < 0 && hr_a[k]) first_hr = k;
         if (vs_a[k]) last_vs = k;
      end
      chk("href_first", first_hr, 62);
      chk("vs_to_href", first_hr - last_vs, 41);
      chk("pix_box", px_a[62], 24'hFFFFFF);
      chk("pix_bg", px_a[66], bg_of(4));
      chk("period_lo", vs_a[221], 0);
      chk("period_hi", vs_a[222], 1);
      check_frame("f0", 0, 0, 0);

      // Bounce over 8 frames.
      for (int f = 0; f < 8; f++) begin
         find_box(f, fbx, fby);
         chk($sformatf("bx_f%0d", f), fbx, exp_bx[f]);
         chk($sformatf("by_f%0d", f), fby, exp_by[f]);
      end
      chk("fcnt_k220", fc_a[220], 0);
      chk("fcnt_k221", fc_a[221], 1);
      chk("fcnt_8", fc_a[8 * FRAME + 1], 8);

`ifdef VS_PATGEN_BAR_EN
      // Line py=5 in frame 0 lies below the box: pure bars.
      for (int h = 0; h < W; h++)
         chk($sformatf("bar_px%0d", h), px_a[(VB + 5) * LINE + h + 2], bg_of(h));
`endif

      // Reset in the middle of an active line.
      found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         @(posedge clk); #1;
         if (href) found = 1'b1;
      end
      chk("href_wait", found, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_out", {4'b0, vsync, href, clken, busy, pix}, 32'h0);
      chk("mid_rst_fcnt", fcnt, 0);
      rst = 1'b0;

      // Restart, then drop gen_en at clk 50 of frame 2 (counter t=490).
      capture(700, 491);
      find_box(0, fbx, fby);
      chk("restart_bx", fbx, 0);
      chk("restart_by", fby, 0);
      chk("restart_fcnt", fc_a[221], 1);
      check_frame("f2", 2, 6, 4);
      chk("drain_busy_last", bz_a[660], 1);
      chk("drain_busy_fall", bz_a[661], 0);
      chk("drain_fcnt_pre", fc_a[660], 2);
      chk("drain_fcnt", fc_a[661], 3);
      cnt = 0;
      for (int k = 492; k <= 660; k++) if (!bz_a[k]) cnt++;
      chk("drain_busy_hold", cnt, 0);
      cnt = 0;
      for (int k = 661; k < 700; k++)
         if (vs_a[k] || hr_a[k] || ce_a[k] || bz_a[k] || px_a[k] != 0 || fc_a[k] != 3) cnt++;
      chk("drain_quiet", cnt, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
